rx_frame_seq: RTL and testbench
===============================

RX_FRAME_SEQ -- requirements
Module: rx_frame_seq

Interface
REQ-001 SHALL have parameter TRAIN_LEN, default 256, giving the training-block length in samples.
REQ-002 SHALL have parameter SYM_LEN, default 64, giving the data-symbol length in samples.
REQ-003 SHALL have port CLK_I, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-004 SHALL have port RST_I, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port DAT_I, input, 32 bits: upstream sample, Im[31:16] and Re[15:0], format 5.11.
REQ-006 SHALL have ports CYC_I, STB_I and WE_I, inputs, 1 bit each: upstream Wishbone frame, strobe and write.
REQ-007 SHALL have port ACK_O, output, 1 bit: upstream acknowledge.
REQ-008 SHALL have port DAT_O, output, 32 bits: downstream sample, same format as DAT_I.
REQ-009 SHALL have ports CYC_O, STB_O and WE_O, outputs, 1 bit each; WE_O = CYC_O.
REQ-010 SHALL have port ACK_I, input, 1 bit: downstream acknowledge.
REQ-011 SHALL have port NSYM_I, input, 8 bits: data symbols per frame, sampled at frame start.
REQ-012 SHALL have port TRN_O, output, 1 bit: DAT_O carries a training sample.
REQ-013 SHALL have port DONE_O, output, 1 bit: one-cycle pulse at clean frame completion.
REQ-014 SHALL have port ERR_O, output, 2 bits: sticky flags, [0] abort, [1] overrun.

Function
REQ-015 SHALL define datin_val = CYC_I & STB_I & WE_I, out_halt = STB_O & ~ACK_I, and ACK_O = datin_val & ~out_halt; ACK_O is combinational.
REQ-016 SHALL define istart = CYC_I & ~CYC_I_pp, with CYC_I_pp registered and reset to 1 (no istart out of reset while CYC_I is high).
REQ-017 SHALL implement states IDLE, TRAIN, DATA, DROP and DRAIN.
REQ-018 SHALL, on istart from any state, go to TRAIN, latch NSYM_I, clear both sample counters, clear ERR_O, and set CYC_O the next cycle; a restart while busy discards the output beat in flight.
REQ-019 SHALL, in TRAIN, pass TRAIN_LEN accepted samples with TRN_O=1, then go to DATA, or to DROP when the latched NSYM = 0.
REQ-020 SHALL, in DATA, pass latched NSYM × SYM_LEN samples with TRN_O=0, using a 16-bit sample counter and an 8-bit symbol counter; after the last accepted sample it goes to DROP.
REQ-021 SHALL have a one-beat output register: on ACK_O load DAT_O and TRN_O and set STB_O next cycle; hold them stable while out_halt; clear STB_O after STB_O & ACK_I with no new ACK_O. Latency DAT_I to DAT_O is 1 cycle.
REQ-022 SHALL, in DROP, still ACK upstream samples but discard them (no STB_O) and set ERR_O[1]; on the last beat's downstream ACK it pulses DONE_O, drops CYC_O the next cycle and goes to IDLE.
REQ-023 SHALL, on CYC_I falling in TRAIN or DATA, set ERR_O[0], go to DRAIN, complete any pending beat, then drop CYC_O with no DONE_O, then go to IDLE.
REQ-024 SHALL, when ACK_O accepts the final sample in the same cycle CYC_I falls next, treat this as a clean completion, not an abort.
REQ-025 SHALL hold ACK_O at 0 in IDLE (CYC_O low) for samples outside a frame.

Reset
REQ-026 SHALL, on RST_I, immediately clear DAT_O, CYC_O, STB_O, TRN_O, DONE_O, ERR_O, all counters and the latched NSYM, and enter IDLE.
REQ-027 SHALL, on reset mid-frame, drop the frame without a DONE_O or ERR_O indication.

Configuration
REQ-028 SHALL, with RX_FRAME_SEQ_STAT_EN defined, add outputs FRM_CNT_O[15:0] (clean frames) and ABT_CNT_O[7:0] (aborts), both saturating and cleared only by RST_I.
REQ-029 SHALL, without RX_FRAME_SEQ_STAT_EN, omit those ports and counters, with all other behaviour identical.

Structure
REQ-030 SHALL place the state enum, the ERR_O bit indices, and default constants TRAIN_LEN_D=256 and SYM_LEN_D=64 in shared package rx_seq_pkg.
REQ-031 SHALL keep the output register and handshake in one sub-module, wb_out_stage, with the FSM and counters in rx_frame_seq.

Verification
REQ-032 SHALL cover: NSYM_I=2, 384 samples with ACK_I always high -> 256 TRN_O=1 beats, then 128 TRN_O=0 beats, DONE_O one pulse, CYC_O low 1 cycle after the last ACK_I, ERR_O=00.
REQ-033 SHALL cover: NSYM_I=0, 256 samples -> DONE_O after beat 256, no TRN_O=0 beat.
REQ-034 SHALL cover: ACK_I low for 5 cycles at beat 10 -> ACK_O low for 5 cycles, DAT_O stable, no sample lost or duplicated.
REQ-035 SHALL cover: CYC_I falls after 300 samples with NSYM_I=2 -> ERR_O=01, no DONE_O, CYC_O low after the pending beat.
REQ-036 SHALL cover: NSYM_I=1, 330 samples -> 10 samples ACKed but not forwarded, ERR_O=10, DONE_O asserted.
REQ-037 SHALL cover: RST_I pulse mid-DATA -> all outputs 0 in the same cycle, and the next CYC_I rise starts a clean frame.

Source files
------------

// File: rtl/rx_seq_pkg.sv
// Shared definitions for the receive frame sequencer: FSM state encoding,
// ERR_O bit positions and default frame geometry.
package rx_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TRAIN = 3'd1,
        ST_DATA  = 3'd2,
        ST_DROP  = 3'd3,
        ST_DRAIN = 3'd4
    } seq_state_t;

    // ERR_O bit positions
    localparam int ERR_ABORT_BIT   = 0;
    localparam int ERR_OVERRUN_BIT = 1;

    // Default frame geometry in samples
    localparam int TRAIN_LEN_D = 256;
    localparam int SYM_LEN_D   = 64;

endpackage

// File: rtl/wb_out_stage.sv
// One-beat downstream output register with Wishbone-style handshake.
// A beat is loaded on 'load', held stable while the sink stalls, and
// retired on STB_O & ACK_I. 'flush' drops a beat in flight (frame restart).
module wb_out_stage (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] beat_dat,
    input  logic        beat_trn,
    input  logic        ACK_I,
    output logic [31:0] DAT_O,
    output logic        TRN_O,
    output logic        STB_O,
    output logic        halt
);

    logic [31:0] dat_reg;
    logic        trn_reg;
    logic        stb_reg;

    // Output beat register: load, hold while stalled, retire on acknowledge
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            dat_reg <= '0;
            trn_reg <= 1'b0;
            stb_reg <= 1'b0;
        end else if (flush) begin
            stb_reg <= 1'b0;
        end else if (load) begin
            dat_reg <= beat_dat;
            trn_reg <= beat_trn;
            stb_reg <= 1'b1;
        end else if (ACK_I) begin
            stb_reg <= 1'b0;
        end
    end

    assign halt  = stb_reg & ~ACK_I;
    assign DAT_O = dat_reg;
    assign TRN_O = trn_reg;
    assign STB_O = stb_reg;

endmodule

// File: rtl/rx_frame_seq.sv
// Receive frame sequencer: forwards TRAIN_LEN training samples followed by
// NSYM x SYM_LEN data samples per upstream frame, discards any surplus,
// and flags aborted (early CYC_I drop) or overrun (surplus samples) frames.
// Optional build macro RX_FRAME_SEQ_STAT_EN adds saturating frame/abort
// counters on FRM_CNT_O / ABT_CNT_O.
module rx_frame_seq
    import rx_seq_pkg::*;
#(
    parameter int TRAIN_LEN = TRAIN_LEN_D,
    parameter int SYM_LEN   = SYM_LEN_D
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] DAT_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    output logic        ACK_O,
    output logic [31:0] DAT_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I,
    input  logic [7:0]  NSYM_I,
    output logic        TRN_O,
    output logic        DONE_O,
    output logic [1:0]  ERR_O
`ifdef RX_FRAME_SEQ_STAT_EN
    ,
    output logic [15:0] FRM_CNT_O,
    output logic [7:0]  ABT_CNT_O
`endif
);

    localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_LEN - 1);
    localparam logic [15:0] SYM_LAST   = 16'(SYM_LEN - 1);

    seq_state_t  state_reg;
    logic        cyc_i_pp_reg;
    logic [15:0] samp_cnt_reg;
    logic [7:0]  sym_cnt_reg;
    logic [7:0]  nsym_reg;
    logic        cyc_o_reg;
    logic        done_reg;
    logic [1:0]  err_reg;

    logic datin_val;
    logic out_halt;
    logic istart;
    logic accepting;
    logic ack_up;
    logic fwd;
    logic abort;
    logic drop_exit;

    assign datin_val = CYC_I & STB_I & WE_I;
    assign istart    = CYC_I & ~cyc_i_pp_reg;
    // The istart cycle itself is not accepted: CYC_O only rises next cycle.
    assign accepting = ((state_reg == ST_TRAIN) | (state_reg == ST_DATA) |
                        (state_reg == ST_DROP)) & ~istart;
    assign ack_up    = datin_val & ~out_halt & accepting;
    assign fwd       = ack_up & ((state_reg == ST_TRAIN) | (state_reg == ST_DATA));
    assign abort     = ((state_reg == ST_TRAIN) | (state_reg == ST_DATA)) & ~CYC_I;
    // Frame finishes once upstream has closed and the last beat has left
    assign drop_exit = (state_reg == ST_DROP) & ~CYC_I & ~out_halt;

    // CYC_I history for rising-edge detection; resets high so a frame already
    // open at reset release is ignored
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) cyc_i_pp_reg <= 1'b1;
        else       cyc_i_pp_reg <= CYC_I;
    end

    // Frame FSM, sample/symbol counters, latched NSYM and status flags
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_reg    <= ST_IDLE;
            samp_cnt_reg <= '0;
            sym_cnt_reg  <= '0;
            nsym_reg     <= '0;
            cyc_o_reg    <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= '0;
        end else begin
            done_reg <= 1'b0;
            if (istart) begin
                state_reg    <= ST_TRAIN;
                nsym_reg     <= NSYM_I;
                samp_cnt_reg <= '0;
                sym_cnt_reg  <= '0;
                err_reg      <= '0;
                cyc_o_reg    <= 1'b1;
            end else begin
                case (state_reg)
                    ST_TRAIN: begin
                        if (abort) begin
                            err_reg[ERR_ABORT_BIT] <= 1'b1;
                            state_reg <= ST_DRAIN;
                        end else if (ack_up) begin
                            if (samp_cnt_reg == TRAIN_LAST) begin
                                samp_cnt_reg <= '0;
                                state_reg    <= (nsym_reg == 8'd0) ? ST_DROP : ST_DATA;
                            end else begin
                                samp_cnt_reg <= samp_cnt_reg + 16'd1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (abort) begin
                            err_reg[ERR_ABORT_BIT] <= 1'b1;
                            state_reg <= ST_DRAIN;
                        end else if (ack_up) begin
                            if (samp_cnt_reg == SYM_LAST) begin
                                samp_cnt_reg <= '0;
                                if (sym_cnt_reg == nsym_reg - 8'd1) state_reg <= ST_DROP;
                                else sym_cnt_reg <= sym_cnt_reg + 8'd1;
                            end else begin
                                samp_cnt_reg <= samp_cnt_reg + 16'd1;
                            end
                        end
                    end
                    ST_DROP: begin
                        if (ack_up) err_reg[ERR_OVERRUN_BIT] <= 1'b1;
                        if (drop_exit) begin
                            done_reg  <= 1'b1;
                            cyc_o_reg <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end
                    ST_DRAIN: begin
                        if (!out_halt) begin
                            cyc_o_reg <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    wb_out_stage u_out (
        .CLK_I    (CLK_I),
        .RST_I    (RST_I),
        .load     (fwd),
        .flush    (istart),
        .beat_dat (DAT_I),
        .beat_trn (state_reg == ST_TRAIN),
        .ACK_I    (ACK_I),
        .DAT_O    (DAT_O),
        .TRN_O    (TRN_O),
        .STB_O    (STB_O),
        .halt     (out_halt)
    );

    assign ACK_O  = ack_up;
    assign CYC_O  = cyc_o_reg;
    assign WE_O   = cyc_o_reg;
    assign DONE_O = done_reg;
    assign ERR_O  = err_reg;

`ifdef RX_FRAME_SEQ_STAT_EN
    logic [15:0] frm_cnt_reg;
    logic [7:0]  abt_cnt_reg;

    // Saturating clean-frame and abort counters, cleared only by reset
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            frm_cnt_reg <= '0;
            abt_cnt_reg <= '0;
        end else begin
            if (drop_exit && (frm_cnt_reg != 16'hFFFF)) frm_cnt_reg <= frm_cnt_reg + 16'd1;
            if (abort && (abt_cnt_reg != 8'hFF))        abt_cnt_reg <= abt_cnt_reg + 8'd1;
        end
    end

    assign FRM_CNT_O = frm_cnt_reg;
    assign ABT_CNT_O = abt_cnt_reg;
`else
    // Statistics counters not built
`endif

endmodule

// File: tb/tb_rx_frame_seq.sv
// Self-checking bench for rx_frame_seq: randomised upstream/downstream
// handshakes checked against a frame-level reference model (first TRAIN_LEN
// accepted samples are training, next NSYM*SYM_LEN are data, rest dropped).
module tb_rx_frame_seq;

    localparam int TRAIN_LEN = 256;
    localparam int SYM_LEN   = 64;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic [31:0] DAT_I;
    logic        CYC_I, STB_I, WE_I, ACK_I;
    logic [7:0]  NSYM_I;
    logic        ACK_O, CYC_O, STB_O, WE_O, TRN_O, DONE_O;
    logic [31:0] DAT_O;
    logic [1:0]  ERR_O;

    rx_frame_seq #(.TRAIN_LEN(TRAIN_LEN), .SYM_LEN(SYM_LEN)) dut (
        .CLK_I (CLK_I), .RST_I (RST_I), .DAT_I (DAT_I), .CYC_I (CYC_I),
        .STB_I (STB_I), .WE_I (WE_I), .ACK_O (ACK_O), .DAT_O (DAT_O),
        .CYC_O (CYC_O), .STB_O (STB_O), .WE_O (WE_O), .ACK_I (ACK_I),
        .NSYM_I (NSYM_I), .TRN_O (TRN_O), .DONE_O (DONE_O), .ERR_O (ERR_O)
    );

    always #5 CLK_I = ~CLK_I;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_n = 0;
    int          hs_cnt, last_hs, done_cnt, done_cyc, cyc_fall, stall_ack_low;
    int          stall_left, frame_no;
    bit          acked, cyc_o_prev, prev_stall, stalled_once;
    logic [31:0] prev_dat;
    logic [32:0] exp_q[$];   // {trn, dat}

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s (frame %0d, cycle %0d): got %0h expected %0h", tag, frame_no, cyc_n, obs, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Downstream acknowledge pattern: 0 always ready, 1 random, 2 one 5-cycle stall at beat 10
    task automatic drive_ack(input int mode);
        if (mode == 1) begin
            ACK_I = ($urandom_range(0, 3) != 0);
        end else if (mode == 2) begin
            if (!stalled_once && hs_cnt == 10) begin
                stall_left   = 5;
                stalled_once = 1;
            end
            if (stall_left > 0) begin
                ACK_I = 1'b0;
                stall_left--;
            end else begin
                ACK_I = 1'b1;
            end
        end else begin
            ACK_I = 1'b1;
        end
    endtask

    // One clock: observe at the falling edge, return 1 ns after the rising edge
    task automatic tick();
        logic [32:0] e;
        @(negedge CLK_I);
        acked = ACK_O;
        if (prev_stall) begin
            check_val("hold_dat", DAT_O, prev_dat);
            check_val("hold_stb", {31'd0, STB_O}, 32'd1);
        end
        if (STB_O && !ACK_I) check_val("ack_in_stall", {31'd0, ACK_O}, 32'd0);
        if (!CYC_O)          check_val("ack_idle", {31'd0, ACK_O}, 32'd0);
        check_val("we_o", {31'd0, WE_O}, {31'd0, CYC_O});
        prev_stall = STB_O & ~ACK_I;
        prev_dat   = DAT_O;
        if (STB_O && ACK_I) begin
            if (exp_q.size() == 0) begin
                check_val("extra_beat", DAT_O, 32'hDEAD_0000);
            end else begin
                e = exp_q.pop_front();
                check_val("beat_dat", DAT_O, e[31:0]);
                check_val("beat_trn", {31'd0, TRN_O}, {31'd0, e[32]});
            end
            hs_cnt++;
            last_hs = cyc_n;
        end
        if (DONE_O) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
        if (cyc_o_prev && !CYC_O && cyc_fall < 0) cyc_fall = cyc_n;
        cyc_o_prev = CYC_O;
        if (STB_I && CYC_I && CYC_O && !ACK_O) stall_ack_low++;
        @(posedge CLK_I);
        #1;
        cyc_n++;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_dat"},  DAT_O, 32'd0);
        check_val({tag, "_ctl"},  {26'd0, CYC_O, STB_O, WE_O, TRN_O, DONE_O, ACK_O}, 32'd0);
        check_val({tag, "_err"},  {30'd0, ERR_O}, 32'd0);
    endtask

    // Run one upstream frame of nsamp accepted samples, then close CYC_I.
    // With do_rst, reset is pulsed instead of closing the frame.
    task automatic run_frame(input int nsym, input int nsamp, input int mode, input bit do_rst);
        int          req, acc, budget, lc, exp_hi;
        bit          over, clean, first;
        logic [31:0] cur;
        logic [1:0]  exp_err;
        frame_no++;
        req = TRAIN_LEN + nsym * SYM_LEN;
        exp_q.delete();
        hs_cnt = 0; done_cnt = 0; cyc_fall = -1; last_hs = -1; done_cyc = -1;
        stall_ack_low = 0; stall_left = 0; stalled_once = 0;
        acc = 0; over = 0; first = 1;
        NSYM_I = nsym[7:0];
        CYC_I = 1'b1; WE_I = 1'b1;
        cur = $urandom;
        budget = 6 * nsamp + 50;
        while (acc < nsamp && budget > 0) begin
            DAT_I = cur;
            STB_I = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            drive_ack(mode);
            tick();
            if (first) begin
                check_val("err_clr", {30'd0, ERR_O}, 32'd0);
                NSYM_I = 8'($urandom);   // must have been latched already
                first = 0;
            end
            if (acked) begin
                if (acc < TRAIN_LEN)  exp_q.push_back({1'b1, cur});
                else if (acc < req)   exp_q.push_back({1'b0, cur});
                else                  over = 1;
                acc++;
                cur = $urandom;
            end
            budget--;
        end
        check_val("up_budget", acc, nsamp);

        if (do_rst) begin
            #2 RST_I = 1'b1;
            #1 check_all_zero("rst_mid");
            exp_q.delete();
            @(posedge CLK_I);
            #1 RST_I = 1'b0;
            cyc_o_prev = 1'b0; prev_stall = 1'b0; done_cnt = 0;
            repeat (3) tick();
            check_val("no_istart", {31'd0, CYC_O}, 32'd0);
            CYC_I = 1'b0; STB_I = 1'b0;
            repeat (2) tick();
            check_val("rst_done", done_cnt, 0);
            check_val("rst_err", {30'd0, ERR_O}, 32'd0);
            $display("frame %0d reset after %0d samples, beats=%0d", frame_no, acc, hs_cnt);
            return;
        end

        CYC_I = 1'b0; STB_I = 1'b0; DAT_I = $urandom;
        lc = cyc_n;
        budget = 200;
        while (cyc_fall < 0 && budget > 0) begin
            drive_ack(mode);
            tick();
            budget--;
        end
        check_val("cyc_o_fall_seen", {31'd0, cyc_fall >= 0}, 32'd1);
        ACK_I = 1'b1;
        repeat (3) tick();

        clean   = (acc >= req);
        exp_err = {over, ~clean};
        check_val("err", {30'd0, ERR_O}, {30'd0, exp_err});
        check_val("done_cnt", done_cnt, clean ? 1 : 0);
        check_val("beats", hs_cnt, (acc < req) ? acc : req);
        check_val("leftover", exp_q.size(), 0);
        if (clean) begin
            check_val("cyc_o_fall", cyc_fall, imax(last_hs, lc) + 1);
            check_val("done_cyc", done_cyc, cyc_fall);
        end else begin
            exp_hi = imax(last_hs, lc + 1) + 1;
            check_val("abort_fall", {31'd0, (cyc_fall > last_hs) && (cyc_fall <= exp_hi)}, 32'd1);
        end
        if (mode == 2) check_val("stall_ack_low", stall_ack_low, 5);
        $display("frame %0d nsym=%0d samples=%0d beats=%0d err=%b done=%0d",
                 frame_no, nsym, acc, hs_cnt, ERR_O, done_cnt);
    endtask

    initial begin
        int nsym, req, nsamp;
        frame_no = 0;
        cyc_o_prev = 1'b0; prev_stall = 1'b0; prev_dat = '0;
        hs_cnt = 0; done_cnt = 0; cyc_fall = -1; last_hs = -1;
        RST_I = 1'b1; CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ACK_I = 1'b1;
        DAT_I = $urandom; NSYM_I = 8'd3;
        repeat (2) @(posedge CLK_I);
        #1 check_all_zero("reset");
        RST_I = 1'b0;
        // CYC_I already high when reset releases: no frame may start
        repeat (3) tick();
        check_val("no_istart_por", {31'd0, CYC_O}, 32'd0);
        CYC_I = 1'b0; STB_I = 1'b0;
        repeat (2) tick();

        run_frame(2, 384, 0, 0);   // nominal frame
        run_frame(0, 256, 0, 0);   // training only
        run_frame(1, 320, 2, 0);   // downstream stall
        run_frame(2, 300, 0, 0);   // early CYC_I drop
        run_frame(1, 330, 0, 0);   // surplus samples
        run_frame(2, 280, 0, 1);   // reset mid-DATA
        run_frame(1, 320, 0, 0);   // clean frame after reset
        for (int i = 0; i < 6; i++) begin
            nsym  = int'($urandom_range(0, 2));
            req   = TRAIN_LEN + nsym * SYM_LEN;
            nsamp = req + int'($urandom_range(0, 12)) - 6;
            run_frame(nsym, nsamp, 1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
